// File: rtl/clk_rst_pkg.sv
// Shared types, default cycle constants and helpers for the PLL reset sequencer.
package clk_rst_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        REL_SDRAM = 3'd2,
        RUN       = 3'd3
    } seq_state_t;

    localparam int DEF_SYNC_STAGES         = 2;
    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_RELEASE_GAP_CYCLES  = 64;
    localparam int DEF_CNT_W               = 17;

    // Event counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level, with a synchronous flush.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else if (flush) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, waits for a stable lock, then releases SDRAM and system resets in order.
module pll_reset_sequencer
    import clk_rst_pkg::*;
#(
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int RELEASE_GAP_CYCLES  = DEF_RELEASE_GAP_CYCLES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sdram_reset_n,
    output logic       sys_reset_n,
    output logic       ready,
    output logic [7:0] retry_count,
    output logic [7:0] loss_count,
    output logic [2:0] state_dbg
);

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RELEASE_GAP_CYCLES - 1);

    seq_state_t       state_q, state_next;
    logic [CNT_W-1:0] timer_q, timer_next;
    logic [CNT_W-1:0] stable_q, stable_next;
    logic [7:0]       retry_next, loss_next;
    logic             locked_s;

    // Held flushed while the PLL is in reset so every attempt observes lock afresh.
    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (pll_rst),
        .d       (pll_locked),
        .q       (locked_s)
    );

    always_comb begin
        state_next  = state_q;
        timer_next  = timer_q + CNT_ONE;
        stable_next = '0;
        retry_next  = retry_count;
        loss_next   = loss_count;

        case (state_q)
            PLL_RST: begin
                if (timer_q == PLL_RST_LAST) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end
            end
            WAIT_LOCK: begin
                stable_next = locked_s ? stable_q + CNT_ONE : '0;
                // Stable completion is checked first so it wins a tie with the timeout.
                if (locked_s && (stable_q == STABLE_LAST)) begin
                    state_next  = REL_SDRAM;
                    timer_next  = '0;
                    stable_next = '0;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_next  = PLL_RST;
                    timer_next  = '0;
                    stable_next = '0;
                    retry_next  = sat_inc8(retry_count);
                end
            end
            REL_SDRAM: begin
                if (!locked_s) begin
                    state_next = PLL_RST;
                    timer_next = '0;
                    loss_next  = sat_inc8(loss_count);
                end else if (timer_q == GAP_LAST) begin
                    state_next = RUN;
                    timer_next = '0;
                end
            end
            RUN: begin
                timer_next = '0;
                if (!locked_s) begin
                    state_next = PLL_RST;
                    loss_next  = sat_inc8(loss_count);
                end
            end
            default: begin
                state_next = PLL_RST;
                timer_next = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= PLL_RST;
            timer_q       <= '0;
            stable_q      <= '0;
            retry_count   <= '0;
            loss_count    <= '0;
            pll_rst       <= 1'b1;
            sdram_reset_n <= 1'b0;
            sys_reset_n   <= 1'b0;
            ready         <= 1'b0;
        end else begin
            state_q       <= state_next;
            timer_q       <= timer_next;
            stable_q      <= stable_next;
            retry_count   <= retry_next;
            loss_count    <= loss_next;
            pll_rst       <= (state_next == PLL_RST);
            sdram_reset_n <= (state_next == REL_SDRAM) || (state_next == RUN);
            sys_reset_n   <= (state_next == RUN);
            ready         <= (state_next == RUN);
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Table-driven bench for pll_reset_sequencer with short cycle parameters.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sdram_reset_n, sys_reset_n, ready;
    logic [7:0] retry_count, loss_count;
    logic [2:0] state_dbg;

    pll_reset_sequencer #(
        .SYNC_STAGES         (2),
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .RELEASE_GAP_CYCLES  (4),
        .CNT_W               (17)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sdram_reset_n (sdram_reset_n),
        .sys_reset_n   (sys_reset_n),
        .ready         (ready),
        .retry_count   (retry_count),
        .loss_count    (loss_count),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pll_rst;
        logic       sdram;
        logic       sys;
        logic       rdy;
        logic [2:0] state;
        logic [7:0] retry;
        logic [7:0] loss;
    } obs_t;

    typedef struct {
        int   scen;
        int   cyc;
        logic locked;
        obs_t exp;
    } vec_t;

    vec_t vecs[$];
    obs_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;

    function automatic obs_t mk(logic r, logic s, logic y, logic d, int st, int rt, int ls);
        obs_t o;
        o.pll_rst = r;
        o.sdram   = s;
        o.sys     = y;
        o.rdy     = d;
        o.state   = 3'(st);
        o.retry   = 8'(rt);
        o.loss    = 8'(ls);
        return o;
    endfunction

    function automatic void add(int scen, int c, logic locked, obs_t e);
        vec_t v;
        v.scen   = scen;
        v.cyc    = c;
        v.locked = locked;
        v.exp    = e;
        vecs.push_back(v);
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.pll_rst = pll_rst;
        o.sdram   = sdram_reset_n;
        o.sys     = sys_reset_n;
        o.rdy     = ready;
        o.state   = state_dbg;
        o.retry   = retry_count;
        o.loss    = loss_count;
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset(logic locked);
        @(negedge clk);
        reset_n    = 1'b0;
        pll_locked = locked;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    task automatic compare(string name);
        obs_t got;
        obs_t exp;
        n_vec++;
        got = observe();
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, got %h", name, got);
        end else begin
            exp = sb_q.pop_front();
            if (got !== exp) begin
                n_bad++;
                $display("FAIL %s at cycle %0d: got %h want %h (pll_rst,sdram_n,sys_n,ready,state,retry,loss)",
                         name, cyc, got, exp);
            end
        end
    endtask

    task automatic expect_now(string name, obs_t e);
        sb_q.push_back(e);
        compare(name);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int cur;
        // Scenario 1: lock held high from power-up.
        add(1,  0, 1, mk(1,0,0,0, 0, 0,0));
        add(1,  3, 1, mk(1,0,0,0, 0, 0,0));
        add(1,  4, 1, mk(0,0,0,0, 1, 0,0));
        add(1, 13, 1, mk(0,0,0,0, 1, 0,0));
        add(1, 14, 1, mk(0,1,0,0, 2, 0,0));
        add(1, 17, 1, mk(0,1,0,0, 2, 0,0));
        add(1, 18, 1, mk(0,1,1,1, 3, 0,0));
        add(1, 30, 1, mk(0,1,1,1, 3, 0,0));
        // Scenario 2: lock never arrives, retry every 36 cycles.
        add(2,   0, 0, mk(1,0,0,0, 0, 0,0));
        add(2,   4, 0, mk(0,0,0,0, 1, 0,0));
        add(2,  35, 0, mk(0,0,0,0, 1, 0,0));
        add(2,  36, 0, mk(1,0,0,0, 0, 1,0));
        add(2,  39, 0, mk(1,0,0,0, 0, 1,0));
        add(2,  40, 0, mk(0,0,0,0, 1, 1,0));
        add(2,  71, 0, mk(0,0,0,0, 1, 1,0));
        add(2,  72, 0, mk(1,0,0,0, 0, 2,0));
        add(2, 108, 0, mk(1,0,0,0, 0, 3,0));
        // Scenario 3: one-cycle glitch after six stable cycles.
        add(3,  0, 1, mk(1,0,0,0, 0, 0,0));
        add(3, 10, 0, mk(0,0,0,0, 1, 0,0));
        add(3, 11, 1, mk(0,0,0,0, 1, 0,0));
        add(3, 20, 1, mk(0,0,0,0, 1, 0,0));
        add(3, 21, 1, mk(0,1,0,0, 2, 0,0));
        add(3, 25, 1, mk(0,1,1,1, 3, 0,0));
        // Scenario 4: lock lost in RUN, then re-acquired.
        add(4,  0, 1, mk(1,0,0,0, 0, 0,0));
        add(4, 18, 1, mk(0,1,1,1, 3, 0,0));
        add(4, 20, 0, mk(0,1,1,1, 3, 0,0));
        add(4, 22, 0, mk(0,1,1,1, 3, 0,0));
        add(4, 23, 1, mk(1,0,0,0, 0, 0,1));
        add(4, 27, 1, mk(0,0,0,0, 1, 0,1));
        add(4, 36, 1, mk(0,0,0,0, 1, 0,1));
        add(4, 37, 1, mk(0,1,0,0, 2, 0,1));
        add(4, 41, 1, mk(0,1,1,1, 3, 0,1));
        // Scenario 5: lock lost during REL_SDRAM, system reset never released.
        add(5,  0, 1, mk(1,0,0,0, 0, 0,0));
        add(5, 14, 0, mk(0,1,0,0, 2, 0,0));
        add(5, 16, 0, mk(0,1,0,0, 2, 0,0));
        add(5, 17, 0, mk(1,0,0,0, 0, 0,1));
        add(5, 21, 0, mk(0,0,0,0, 1, 0,1));
        add(5, 22, 0, mk(0,0,0,0, 1, 0,1));
        // Scenario 6: stable completion lands on the timeout cycle; stable wins.
        add(6,  0, 0, mk(1,0,0,0, 0, 0,0));
        add(6, 26, 1, mk(0,0,0,0, 1, 0,0));
        add(6, 35, 1, mk(0,0,0,0, 1, 0,0));
        add(6, 36, 1, mk(0,1,0,0, 2, 0,0));
        add(6, 40, 1, mk(0,1,1,1, 3, 0,0));

        cur = -1;
        foreach (vecs[i]) begin
            if (vecs[i].scen != cur) begin
                cur = vecs[i].scen;
                do_reset(vecs[i].locked);
            end
            run_to(vecs[i].cyc);
            sb_q.push_back(vecs[i].exp);
            compare($sformatf("scen%0d_cyc%0d", cur, vecs[i].cyc));
            pll_locked = vecs[i].locked;
        end

        // Asynchronous reset in REL_SDRAM with a nonzero retry count.
        do_reset(1'b0);
        run_to(36);
        pll_locked = 1'b1;
        run_to(51);
        expect_now("pre_async_rst", mk(0,1,0,0, 2, 1,0));
        #2;
        reset_n = 1'b0;
        #1;
        expect_now("async_rst_immediate", mk(1,0,0,0, 0, 0,0));
        @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;
        expect_now("async_rst_release", mk(1,0,0,0, 0, 0,0));
        run_to(4);
        expect_now("restart_wait_lock", mk(0,0,0,0, 1, 0,0));
        run_to(14);
        expect_now("restart_rel_sdram", mk(0,1,0,0, 2, 0,0));

        // Retry counter saturation over 300 timeouts.
        do_reset(1'b0);
        run_to(36 * 255 - 1);
        expect_now("retry_254", mk(0,0,0,0, 1, 254,0));
        run_to(36 * 255);
        expect_now("retry_255", mk(1,0,0,0, 0, 255,0));
        run_to(36 * 256);
        expect_now("retry_no_wrap", mk(1,0,0,0, 0, 255,0));
        run_to(36 * 300);
        expect_now("retry_sat_300", mk(1,0,0,0, 0, 255,0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
